// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler that feeds bytes from NUM_REQ
// requesters to a single UART sender, one whole frame per grant, with an
// enforced idle gap between frames and a timeout on stalled requesters.
module uart_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 255,
    localparam int GW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 snd_valid,
    output logic [7:0]           snd_data,
    input  logic                 snd_done,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 abort
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_GAP} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] r_last_grant;
    logic [7:0]    r_snd_data;
    logic          r_snd_valid;
    logic          r_last;
    logic          r_frame_done;
    logic          r_abort;
    logic [7:0]    r_tcnt;
    logic [7:0]    r_gcnt;

    logic [GW-1:0] w_rr_pick;
    logic          w_any_valid;
    logic          w_gnt_valid;
    logic          w_hs;
    logic [8:0]    w_tcnt_inc;
    logic          w_timeout;
    logic [8:0]    w_gcnt_inc;
    logic          w_gap_end;
    logic          w_frame_end;

    assign w_any_valid = |req_valid;
    assign w_gnt_valid = req_valid[r_grant_id];
    assign w_hs        = (r_state == S_FETCH) && w_gnt_valid;
    assign w_tcnt_inc  = {1'b0, r_tcnt} + 9'd1;
    // The counter only advances while the owner is stalled, so reaching
    // TIMEOUT on this increment is the abort condition.
    assign w_timeout   = (r_state == S_FETCH) && !w_gnt_valid && (w_tcnt_inc == 9'(TIMEOUT));
    assign w_gcnt_inc  = {1'b0, r_gcnt} + 9'd1;
    // GAP always lasts at least one cycle, so GAP_CYCLES of 0 and 1 behave alike.
    assign w_gap_end   = (r_state == S_GAP) && (w_gcnt_inc >= 9'(GAP_CYCLES));
    assign w_frame_end = ((r_state == S_SEND) && snd_done && r_last) || w_timeout;

    // Round-robin pick: nearest valid requester after last_grant wins.
    always_comb begin
        int idx;
        w_rr_pick = r_last_grant;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (req_valid[GW'(idx)]) w_rr_pick = GW'(idx);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_hs)           w_state_nxt = S_SEND;
                else if (w_timeout) w_state_nxt = S_GAP;
            end
            S_SEND:  if (snd_done) w_state_nxt = r_last ? S_GAP : S_FETCH;
            S_GAP:   if (w_gap_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Combinational outputs: ready only toward the owner while fetching.
    always_comb begin
        req_ready = '0;
        busy      = (r_state != S_IDLE);
        if (r_state == S_FETCH) req_ready[r_grant_id] = w_gnt_valid;
    end

    // Grant bookkeeping, byte capture, counters and one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant_id   <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_snd_data   <= '0;
            r_snd_valid  <= 1'b0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_abort      <= 1'b0;
            r_tcnt       <= '0;
            r_gcnt       <= '0;
        end else begin
            r_snd_valid  <= w_hs;
            r_frame_done <= (r_state == S_SEND) && snd_done && r_last;
            r_abort      <= w_timeout;
            if ((r_state == S_IDLE) && w_any_valid) r_grant_id <= w_rr_pick;
            if (w_hs) begin
                r_snd_data <= req_data[{r_grant_id, 3'b000} +: 8];
                r_last     <= req_last[r_grant_id];
            end
            if (w_frame_end) r_last_grant <= r_grant_id;
            if (w_hs || (r_state == S_IDLE))
                r_tcnt <= '0;
            else if ((r_state == S_FETCH) && !w_gnt_valid)
                r_tcnt <= w_tcnt_inc[7:0];
            if ((r_state == S_GAP) && !w_gap_end)
                r_gcnt <= w_gcnt_inc[7:0];
            else
                r_gcnt <= '0;
        end
    end

    assign snd_valid  = r_snd_valid;
    assign snd_data   = r_snd_data;
    assign grant_id   = r_grant_id;
    assign frame_done = r_frame_done;
    assign abort      = r_abort;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requester queues and a delayed-done sender model
// drive the DUT cycle by cycle; accepted bytes go to a scoreboard that is
// compared against every snd_valid pulse.
module tb_uart_tx_sched;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic         snd_valid;
    logic [7:0]   snd_data;
    logic         snd_done;
    logic [1:0]   grant_id;
    logic         busy;
    logic         frame_done;
    logic         abort;

    uart_tx_sched #(.NUM_REQ(N), .GAP_CYCLES(2), .TIMEOUT(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .snd_valid(snd_valid), .snd_data(snd_data), .snd_done(snd_done),
        .grant_id(grant_id), .busy(busy),
        .frame_done(frame_done), .abort(abort)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n = 0;
    int fd_cnt = 0;
    int ab_cnt = 0;
    int t_done = 0;
    int t_abort = 0;
    int t_sv = 0;
    int t_sv_prev = 0;
    int dly = 3;
    int cd = 0;
    bit pend = 0;
    bit fd_exp = 0;
    bit infl_last = 0;
    logic [N-1:0] en = '1;

    logic [8:0]  rq [0:N-1][$];   // per requester: {last, data}
    logic [10:0] sb [$];          // scoreboard: {grant, last, data}
    logic [1:0]  glog [$];        // grant_id seen at each snd_valid

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit anyq();
        bit r = 0;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) r = 1;
        return r;
    endfunction

    task automatic cyc();
        logic [10:0] e;
        logic [8:0]  h;
        @(negedge clk);
        cyc_n++;
        chk("frame_done", frame_done, fd_exp);
        fd_exp = 0;
        if (frame_done) fd_cnt++;
        if (abort) begin ab_cnt++; t_abort = cyc_n; end
        if (snd_valid) begin
            t_sv_prev = t_sv;
            t_sv = cyc_n;
            glog.push_back(grant_id);
            if (sb.size() == 0) begin
                chk("snd_valid_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("snd_data", snd_data, e[7:0]);
                chk("grant_id", grant_id, e[10:9]);
                infl_last = e[8];
            end
            pend = 1;
            cd = dly;
        end else if (pend) begin
            cd--;
        end
        snd_done = 0;
        if (pend && cd == 0) begin
            snd_done = 1;
            pend = 0;
            t_done = cyc_n;
            if (infl_last && !rst) fd_exp = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (en[i] && rq[i].size() != 0) begin
                h = rq[i][0];
                req_valid[i] = 1'b1;
                req_data[8*i +: 8] = h[7:0];
                req_last[i] = h[8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i] = 1'b0;
            end
        end
        #1;
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i] && !rst) begin
                h = rq[i].pop_front();
                sb.push_back({2'(i), h});
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || pend || sb.size() != 0 || anyq()) && n < 400) begin
            cyc();
            n++;
        end
        chk("drain_idle", busy, 0);
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_snd_valid"}, snd_valid, 0);
        chk({pfx, "_req_ready"}, req_ready, 0);
        chk({pfx, "_frame_done"}, frame_done, 0);
        chk({pfx, "_abort"}, abort, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_snd_data"}, snd_data, 0);
        chk({pfx, "_grant_id"}, grant_id, 0);
    endtask

    initial begin
        int n;
        int fd0;
        int sv0;
        int ab0;
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        snd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;

        // Round robin: every requester holds two single-byte frames.
        dly = 3;
        en = '1;
        for (int i = 0; i < N; i++) begin
            rq[i].push_back({1'b1, 8'h10 + 8'(i)});
            rq[i].push_back({1'b1, 8'h20 + 8'(i)});
        end
        n = 0;
        while (fd_cnt < 8 && n < 600) begin cyc(); n++; end
        chk("rr_frame_count", fd_cnt, 8);
        for (int k = 0; k < 8; k++)
            chk("rr_order", (k < glog.size()) ? 32'(glog[k]) : 32'hFF, k % 4);
        drain();

        // Two-byte frame from requester 2, sender done 10 cycles after start.
        dly = 10;
        rq[2].push_back({1'b0, 8'h55});
        rq[2].push_back({1'b1, 8'hA3});
        fd0 = fd_cnt;
        sv0 = glog.size();
        n = 0;
        while (fd_cnt == fd0 && n < 200) begin cyc(); n++; end
        chk("single_frame_done", fd_cnt, fd0 + 1);
        chk("single_pulses", glog.size() - sv0, 2);
        chk("single_grant", (glog.size() > sv0) ? 32'(glog[sv0]) : 32'hFF, 2);
        n = 0;
        while (busy && n < 20) begin cyc(); n++; end
        chk("busy_drop_delay", cyc_n - t_done, 3);

        // Timeout: requester 1 sends one non-last byte then goes quiet.
        dly = 2;
        en = 4'b0010;
        rq[1].push_back({1'b0, 8'h11});
        ab0 = ab_cnt;
        n = 0;
        while (rq[1].size() != 0 && n < 50) begin cyc(); n++; end
        rq[0].push_back({1'b1, 8'h66});
        rq[3].push_back({1'b1, 8'h77});
        en = 4'b1011;
        n = 0;
        while (ab_cnt == ab0 && n < 60) begin cyc(); n++; end
        chk("abort_seen", ab_cnt, ab0 + 1);
        chk("abort_latency", t_abort - t_done, 6);
        sv0 = glog.size();
        n = 0;
        while (glog.size() <= sv0 && n < 60) begin cyc(); n++; end
        chk("grant_after_abort", (glog.size() > sv0) ? 32'(glog[sv0]) : 32'hFF, 3);
        drain();
        chk("abort_once", ab_cnt, ab0 + 1);

        // Back-to-back: done arrives in the same cycle as snd_valid.
        dly = 0;
        en = '1;
        rq[0].push_back({1'b0, 8'hC1});
        rq[0].push_back({1'b1, 8'hC2});
        fd0 = fd_cnt;
        sv0 = glog.size();
        n = 0;
        while (fd_cnt == fd0 && n < 60) begin cyc(); n++; end
        chk("b2b_frame_done", fd_cnt, fd0 + 1);
        chk("b2b_pulses", glog.size() - sv0, 2);
        chk("b2b_spacing", t_sv - t_sv_prev, 2);
        drain();

        // Reset in SEND during a three-byte frame from requester 1.
        dly = 10;
        rq[1].push_back({1'b0, 8'hE1});
        rq[1].push_back({1'b0, 8'hE2});
        rq[1].push_back({1'b1, 8'hE3});
        sv0 = glog.size();
        n = 0;
        while (glog.size() <= sv0 && n < 60) begin cyc(); n++; end
        cyc();
        chk("pre_reset_busy", busy, 1);
        fd0 = fd_cnt;
        ab0 = ab_cnt;
        rst = 1'b1;
        cyc();
        @(posedge clk);
        #1;
        chk_reset_outs("midreset");
        rst = 1'b0;
        for (int i = 0; i < N; i++) rq[i].delete();
        sb.delete();
        pend = 0;
        fd_exp = 0;
        infl_last = 0;
        rq[0].push_back({1'b1, 8'hF0});
        rq[1].push_back({1'b1, 8'hF1});
        sv0 = glog.size();
        n = 0;
        while (glog.size() <= sv0 && n < 60) begin cyc(); n++; end
        chk("first_grant_after_reset", (glog.size() > sv0) ? 32'(glog[sv0]) : 32'hFF, 0);
        drain();
        chk("no_abort_after_reset", ab_cnt, ab0);
        chk("frames_after_reset", fd_cnt, fd0 + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
